// File: rtl/button_debouncer.sv
// Push-button conditioner: synchronises the raw pin, rejects contact bounce and
// emits one-cycle press/release/long-press strobes plus a debounced level.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES   = 100000,
    parameter int unsigned LONG_PRESS_CYCLES = 10000000,
    parameter bit          BTN_ACTIVE_LOW    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic              btn_meta;
    logic              btn_sync;
    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_nxt;
    logic              fired;
    logic              fired_nxt;
    logic              level_nxt;
    logic              press_nxt;
    logic              release_nxt;
    logic              long_nxt;

    // Polarity-normalise, then two-flop synchronise the asynchronous pin
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn_raw ^ BTN_ACTIVE_LOW;
            btn_sync <= btn_meta;
        end
    end

    // Next-state and next-output logic for the debounce/hold FSM
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        hold_nxt    = hold;
        fired_nxt   = fired;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        case (state)
            IDLE: begin
                level_nxt = 1'b0;
                if (btn_sync) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    press_nxt = 1'b1;
                    level_nxt = 1'b1;
                    hold_nxt  = '0;
                    fired_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = '0;
                end else if (hold == HOLD_LAST) begin
                    // Hold counter saturates; the fired flag limits this to one strobe per press
                    if (!fired) begin
                        long_nxt  = 1'b1;
                        fired_nxt = 1'b1;
                    end
                end else begin
                    hold_nxt = hold + 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (btn_sync) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                    level_nxt   = 1'b0;
                    fired_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                level_nxt = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            cnt              <= '0;
            hold             <= '0;
            fired            <= 1'b0;
            btn_level        <= 1'b0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            hold             <= hold_nxt;
            fired            <= fired_nxt;
            btn_level        <= level_nxt;
            press_pulse      <= press_nxt;
            release_pulse    <= release_nxt;
            long_press_pulse <= long_nxt;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: per-cycle scoreboard for exact latencies plus a
// segment table checking event counts, using an active-high and an active-low instance.
module tb_button_debouncer;

    localparam int unsigned N = 4;
    localparam int unsigned L = 20;

    logic clk;
    logic rst;
    logic btn_a;
    logic btn_b;
    logic a_level, a_press, a_rel, a_long;
    logic b_level, b_press, b_rel, b_long;

    button_debouncer #(
        .DEBOUNCE_CYCLES  (N),
        .LONG_PRESS_CYCLES(L),
        .BTN_ACTIVE_LOW   (1'b0)
    ) dut_a (
        .clk             (clk),
        .rst             (rst),
        .btn_raw         (btn_a),
        .btn_level       (a_level),
        .press_pulse     (a_press),
        .release_pulse   (a_rel),
        .long_press_pulse(a_long)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES  (N),
        .LONG_PRESS_CYCLES(L),
        .BTN_ACTIVE_LOW   (1'b1)
    ) dut_b (
        .clk             (clk),
        .rst             (rst),
        .btn_raw         (btn_b),
        .btn_level       (b_level),
        .press_pulse     (b_press),
        .release_pulse   (b_rel),
        .long_press_pulse(b_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] outs;
    } exp_t;

    typedef struct {
        logic btn;
        int   cycles;
        int   press;
        int   rel;
        int   lng;
        logic level;
        logic steady;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[13];
    int         pass_cnt;
    int         chk_cnt;
    int         n_press, n_rel, n_long, n_low, n_clash;
    logic [5:0] prev_pulses;

    function automatic logic [7:0] ea(input logic lvl, input logic p, input logic r, input logic lg);
        return {lvl, p, r, lg, 4'b0000};
    endfunction

    function automatic logic [7:0] eb(input logic lvl, input logic p, input logic r, input logic lg);
        return {4'b0000, lvl, p, r, lg};
    endfunction

    task automatic check(input string name, input int act, input int req);
        chk_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Observe outputs on the falling edge; pop and compare any pending expectation
    task automatic sample();
        logic [7:0] outs;
        logic [5:0] pulses;
        exp_t       e;
        outs   = {a_level, a_press, a_rel, a_long, b_level, b_press, b_rel, b_long};
        pulses = {a_press, a_rel, a_long, b_press, b_rel, b_long};
        n_press += int'(a_press);
        n_rel   += int'(a_rel);
        n_long  += int'(a_long);
        if (!a_level) n_low++;
        if ((int'(a_press) + int'(a_rel) + int'(a_long)) > 1) n_clash++;
        if ((int'(b_press) + int'(b_rel) + int'(b_long)) > 1) n_clash++;
        if ((prev_pulses & pulses) != 6'b0) n_clash++;
        prev_pulses = pulses;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_cnt++;
            if (outs == e.outs) pass_cnt++;
            else $display("FAIL %s: outs=%b expected %b", e.tag, outs, e.outs);
        end
    endtask

    task automatic step(input logic a, input logic b, input logic chk, input string tag,
                        input logic [7:0] e);
        exp_t x;
        btn_a = a;
        btn_b = b;
        if (chk) begin
            x.tag  = tag;
            x.outs = e;
            exp_q.push_back(x);
        end
        @(posedge clk);
        @(negedge clk);
        sample();
        #1;
    endtask

    initial begin
        int s_press, s_rel, s_long, s_low;
        pass_cnt    = 0;
        chk_cnt     = 0;
        n_press     = 0;
        n_rel       = 0;
        n_long      = 0;
        n_low       = 0;
        n_clash     = 0;
        prev_pulses = '0;
        rst   = 1'b1;
        btn_a = 1'b0;
        btn_b = 1'b1;
        #2 rst = 1'b0;

        // Reset held while both pins toggle, then released with buttons idle
        for (int i = 0; i < 20; i++) step(1'(i % 2), 1'(i % 2), 1'b1, "reset_hold", 8'h00);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, "reset_release", 8'h00);

        // Clean press/release: edges counted from the first sampling edge
        for (int i = 1; i <= 12; i++) step(1'b1, 1'b1, 1'b1, "clean_press", ea(i >= 7, i == 7, 1'b0, 1'b0));
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b1, 1'b1, "clean_release", ea(i < 7, 1'b0, i == 7, 1'b0));

        // Long press fires exactly L cycles after the press strobe, once
        for (int i = 1; i <= 40; i++) step(1'b1, 1'b1, 1'b1, "long_hold", ea(i >= 7, i == 7, 1'b0, i == 27));
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b1, 1'b1, "long_release", ea(i < 7, 1'b0, i == 7, 1'b0));

        // Active-low instance
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b0, 1'b1, "low_press", eb(i >= 7, i == 7, 1'b0, 1'b0));
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b1, 1'b1, "low_release", eb(i < 7, 1'b0, i == 7, 1'b0));

        // Reset asserted at edge 5 of a press; held button is re-debounced afterwards
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b1, "abort_pre", 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, "abort_rst", 8'h00);
        rst = 1'b1;
        for (int i = 1; i <= 12; i++) step(1'b1, 1'b1, 1'b1, "abort_repress", ea(i >= 7, i == 7, 1'b0, 1'b0));
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b1, 1'b1, "abort_release", ea(i < 7, 1'b0, i == 7, 1'b0));

        // Segment table: btn, cycles, press, release, long counts, end level, level held high
        vecs[0]  = '{1'b0, 5,  0, 0, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 12, 1, 0, 0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 12, 0, 1, 0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 3,  0, 0, 0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 10, 0, 0, 0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 12, 1, 0, 0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 2,  0, 0, 0, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 10, 0, 0, 0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 12, 0, 1, 0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 60, 1, 0, 1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 12, 0, 1, 0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 60, 1, 0, 1, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 12, 0, 1, 0, 1'b0, 1'b0};

        for (int k = 0; k < 13; k++) begin
            s_press = n_press;
            s_rel   = n_rel;
            s_long  = n_long;
            s_low   = n_low;
            for (int c = 0; c < vecs[k].cycles; c++) step(vecs[k].btn, 1'b1, 1'b0, "", 8'h00);
            check($sformatf("vec%0d_press", k), n_press - s_press, vecs[k].press);
            check($sformatf("vec%0d_release", k), n_rel - s_rel, vecs[k].rel);
            check($sformatf("vec%0d_long", k), n_long - s_long, vecs[k].lng);
            check($sformatf("vec%0d_level", k), int'(a_level), int'(vecs[k].level));
            if (vecs[k].steady) check($sformatf("vec%0d_level_steady", k), n_low - s_low, 0);
        end

        check("pulse_overlap_or_width", n_clash, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
